// File: rtl/dual_counter_sched_if.sv
// Bus between the dual-counter scheduler and its requesters/observers.
// The testbench or upstream logic uses the master side; the scheduler uses the slave side.
interface dual_counter_sched_if #(
  parameter int W  = 12,
  parameter int CW = 4
);
  // Handshake: req1/req2 each carry one increment per cycle sampled high and have no ready.
  // A req is taken unless that requester's credit counter is full (full1/full2) and it is
  // not being granted in the same cycle; a refused req is dropped. ena1/ena2 are one-cycle
  // grants and the matching count changes at the next clk edge.
  logic          clr;
  logic          req1;
  logic          req2;
  logic          ena1;
  logic          ena2;
  logic [W-1:0]  count1;
  logic [W-1:0]  count2;
  logic [CW-1:0] pend1;
  logic [CW-1:0] pend2;
  logic          full1;
  logic          full2;
  logic          busy;
  logic          halted;
  logic          valid;
  logic [1:0]    state_dbg;

  modport master (
    output clr, req1, req2,
    input  ena1, ena2, count1, count2, pend1, pend2,
    input  full1, full2, busy, halted, valid, state_dbg
  );

  modport slave (
    input  clr, req1, req2,
    output ena1, ena2, count1, count2, pend1, pend2,
    output full1, full2, busy, halted, valid, state_dbg
  );
endinterface

// File: rtl/dual_counter_sched.sv
// Two W-bit counters sharing one increment slot, scheduled round-robin from per-requester credits.
// Define SCHED_FIXED_PRIO_EN to give requester 1 strict priority instead of round-robin.
module dual_counter_sched #(
  parameter int W  = 12,
  parameter int CW = 4
) (
  input logic                clk,
  input logic                rst,
  dual_counter_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [CW-1:0] PMAX = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  count1_q, count1_d;
  logic [W-1:0]  count2_q, count2_d;
  logic [CW-1:0] pend1_q, pend1_d;
  logic [CW-1:0] pend2_q, pend2_d;
  logic          last2_q, last2_d;  // 1: requester 2 received the most recent grant
  logic          g1, g2;
  logic          acc1, acc2;

  // Grants depend only on registered state, so they are glitch-free within the cycle.
  always_comb begin
    g1 = 1'b0;
    g2 = 1'b0;
    if (state_q == RUN) begin
      if (pend1_q != '0 && pend2_q != '0) begin
`ifdef SCHED_FIXED_PRIO_EN
        g1 = 1'b1;
`else
        if (last2_q) g1 = 1'b1;
        else         g2 = 1'b1;
`endif
      end else if (pend1_q != '0) begin
        g1 = 1'b1;
      end else if (pend2_q != '0) begin
        g2 = 1'b1;
      end
    end
  end

  always_comb begin
    acc1     = bus.req1 && (pend1_q != PMAX || g1);
    acc2     = bus.req2 && (pend2_q != PMAX || g2);
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    count1_d = count1_q;
    count2_d = count2_q;
    last2_d  = last2_q;
    state_d  = state_q;

    if (acc1 && !g1)      pend1_d = pend1_q + 1'b1;
    else if (!acc1 && g1) pend1_d = pend1_q - 1'b1;
    if (acc2 && !g2)      pend2_d = pend2_q + 1'b1;
    else if (!acc2 && g2) pend2_d = pend2_q - 1'b1;

    if (g1) begin
      count1_d = count1_q + 1'b1;
      last2_d  = 1'b0;
    end
    if (g2) begin
      count2_d = count2_q + 1'b1;
      last2_d  = 1'b1;
    end

    if (state_q == HALT)                   state_d = HALT;
    else if ((&count1_d) && (&count2_d))   state_d = HALT;
    else if (pend1_d != '0 || pend2_d != '0) state_d = RUN;
    else                                   state_d = IDLE;

    // Clear wins over everything, including a req or grant in the same cycle.
    if (bus.clr) begin
      pend1_d  = '0;
      pend2_d  = '0;
      count1_d = '0;
      count2_d = '0;
      last2_d  = 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count1_q <= '0;
      count2_q <= '0;
      pend1_q  <= '0;
      pend2_q  <= '0;
      last2_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count1_q <= count1_d;
      count2_q <= count2_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      last2_q  <= last2_d;
    end
  end

  assign bus.ena1      = g1;
  assign bus.ena2      = g2;
  assign bus.count1    = count1_q;
  assign bus.count2    = count2_q;
  assign bus.pend1     = pend1_q;
  assign bus.pend2     = pend2_q;
  assign bus.full1     = (pend1_q == PMAX);
  assign bus.full2     = (pend2_q == PMAX);
  assign bus.busy      = (state_q == RUN);
  assign bus.halted    = (state_q == HALT);
  assign bus.valid     = !((&count1_q) && (&count2_q));
  assign bus.state_dbg = state_q;

endmodule
